red_pitaya_led_drv: RTL and testbench
=====================================

Name: red_pitaya_led_drv

Overview:
Output stage directly downstream of the housekeeping block's LED register. It takes the 8-bit LED word from housekeeping and drives the board LED pins. A per-LED mode selects pass-through, PWM dimming, or blinking. It has its own system-bus register window for mode, brightness and blink period.

Parameters:
DWL, 8, number of LEDs
PRESC, 1250, clk_i cycles per tick (125 MHz / 1250 = 100 kHz tick); legal range 2..65535
BLINK_RST, 50000, reset value of the blink half-period, in ticks

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
led_i  in  DWL  LED request word from housekeeping
led_o  out  DWL  LED pin drive, registered
sys_addr  in  32  bus address
sys_wdata  in  32  bus write data
sys_sel  in  4  byte select (ignored; full-word writes only)
sys_wen  in  1  bus write enable
sys_ren  in  1  bus read enable
sys_rdata  out  32  bus read data
sys_err  out  1  bus error, always 0
sys_ack  out  1  bus acknowledge

Behaviour:
- Reset (async assert, sync release): led_o=0, sys_rdata=0, sys_ack=0, sys_err=0, mode=0, bright=8'hFF, half=BLINK_RST, all counters=0, phase=0.
- Registers, decoded on sys_addr[19:0]:
  - 0x00 MODE (RW), 2*DWL bits, 2 bits per LED n at [2n+1:2n]: 0 pass, 1 PWM, 2 blink, 3 breathe.
  - 0x04 BRIGHT (RW), [7:0].
  - 0x08 HALF (RW), [15:0].
  - 0x0C STATUS (RO): {15'b0, phase, 8'b0, pwm_cnt}.
  - Unmapped addresses read 0; writes to them are ignored.
- Bus timing: sys_ack = registered (sys_wen|sys_ren), asserted one cycle after the request. sys_rdata is valid in the same cycle as sys_ack. Writes take effect on the clock edge that samples sys_wen. sys_err=0 always.
- Prescaler: counts 0..PRESC-1 then wraps. tick=1 for one cycle when the count equals PRESC-1.
- pwm_cnt: 8-bit, increments on tick, wraps 255->0.
- Blink counter: 16-bit, increments on tick.
  - When the counter reaches max(HALF,1)-1 on a tick, it clears and phase toggles.
  - A write to HALF clears the blink counter and phase in the same edge.
- Per-LED output, computed combinationally, then registered into led_o (1-cycle latency from led_i/state):
  - mode0: led_i[n]
  - mode1: led_i[n] & (pwm_cnt < BRIGHT). BRIGHT=0 gives always off; BRIGHT=255 gives on 255 of 256 ticks.
  - mode2: led_i[n] & phase
  - mode3: see Optional Feature.
- led_i is synchronous to clk_i; no synchronizer.
- Simultaneous write to HALF and a phase-toggling tick: the write wins (counter=0, phase=0).

Optional Feature:
- Macro: LED_BREATHE_EN.
- When defined, a breathe engine is built:
  - 8-bit level plus up/down direction bit.
  - Level steps by 1 each time pwm_cnt wraps 255->0.
  - Counts 0 up to 255, reverses, then down to 0, and repeats.
  - mode3 output: led_i[n] & (pwm_cnt < level).
  - STATUS[15:8] = level.
- When not defined: no breathe logic; mode3 behaves as mode0; STATUS[15:8] reads 0; MODE still stores and reads back 3.

Test Plan:
- Reset: assert rstn_i mid-operation -> led_o=0 immediately (asynchronous); after release, reads return 0x0 at 0x00, 0xFF at 0x04, 50000 at 0x08; sys_ack 1 cycle after each sys_ren.
- Pass-through: mode=0, led_i=8'hA5 -> led_o=8'hA5 one clk later; read of 0x40 returns 0 with ack, sys_err=0.
- PWM: PRESC=4, MODE=0x0001, BRIGHT=64, led_i=1 -> led_o[0] high exactly 64 of each 256 ticks (256 clk high per 1024 clk); BRIGHT=0 -> never high.
- Blink: PRESC=4, MODE=0x0002, HALF=3, led_i=1 -> led_o[0] toggles every 12 clk; HALF=0 -> toggles every 4 clk; write HALF while phase=1 -> phase=0 next cycle.
- Bus: back-to-back writes 0x00=0xFFFF then read 0x00 -> 0x0000FFFF; write to 0x0C ignored.
- Breathe (LED_BREATHE_EN): PRESC=2, MODE=0x0003 -> STATUS[15:8] ramps 0..255..0 with period 510*256 ticks; without macro, led_o[0]=led_i[0].

Source files
------------

// File: rtl/red_pitaya_led_drv.sv
// Board LED output stage: per-LED pass-through / PWM dim / blink / breathe modes,
// with its own system-bus register window. Define LED_BREATHE_EN to build the breathe engine.
module red_pitaya_led_drv #(
  parameter int DWL       = 8,
  parameter int PRESC     = 1250,
  parameter int BLINK_RST = 50000
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [DWL-1:0]   led_i,
  output logic [DWL-1:0]   led_o,
  input  logic [31:0]      sys_addr,
  input  logic [31:0]      sys_wdata,
  input  logic [3:0]       sys_sel,
  input  logic             sys_wen,
  input  logic             sys_ren,
  output logic [31:0]      sys_rdata,
  output logic             sys_err,
  output logic             sys_ack
);

  localparam logic [19:0] ADDR_MODE   = 20'h00;
  localparam logic [19:0] ADDR_BRIGHT = 20'h04;
  localparam logic [19:0] ADDR_HALF   = 20'h08;
  localparam logic [19:0] ADDR_STATUS = 20'h0C;

  localparam logic [15:0] PRESC_LAST = 16'(PRESC - 1);

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_PWM     = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_e;

  logic [2*DWL-1:0] mode;
  logic [7:0]       bright;
  logic [15:0]      half;
  logic [15:0]      presc_cnt;
  logic [7:0]       pwm_cnt;
  logic [15:0]      blink_cnt;
  logic [15:0]      blink_last;
  logic             phase;
  logic             tick;
  logic             pwm_wrap;
  logic [7:0]       level;
  logic [19:0]      addr;
  logic             wr_mode, wr_bright, wr_half;
  logic [31:0]      rd_mux;
  logic [DWL-1:0]   led_next;
  logic             unused;

  // Byte selects and the upper address/data bits carry no meaning here.
  assign unused = ^{sys_sel, sys_addr, sys_wdata};

  assign addr      = sys_addr[19:0];
  assign wr_mode   = sys_wen && (addr == ADDR_MODE);
  assign wr_bright = sys_wen && (addr == ADDR_BRIGHT);
  assign wr_half   = sys_wen && (addr == ADDR_HALF);

  assign tick       = (presc_cnt == PRESC_LAST);
  assign pwm_wrap   = tick && (pwm_cnt == 8'hFF);
  assign blink_last = (half == 16'd0) ? 16'd0 : half - 16'd1;

  // NOTE: every flop below uses non-blocking assignments so all state updates
  // see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mode   <= '0;
      bright <= 8'hFF;
      half   <= 16'(BLINK_RST);
    end else begin
      if (wr_mode)   mode   <= sys_wdata[2*DWL-1:0];
      if (wr_bright) bright <= sys_wdata[7:0];
      if (wr_half)   half   <= sys_wdata[15:0];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      presc_cnt <= tick ? 16'd0 : presc_cnt + 16'd1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // A HALF write restarts the blink cycle and overrides a coincident toggle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (wr_half) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == blink_last) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

`ifdef LED_BREATHE_EN
  logic dir_up;

  // Triangle ramp 0..255..0, one step per full PWM period.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      level  <= '0;
      dir_up <= 1'b1;
    end else if (pwm_wrap) begin
      if (dir_up) begin
        if (level == 8'hFF) begin
          dir_up <= 1'b0;
          level  <= level - 8'd1;
        end else begin
          level  <= level + 8'd1;
        end
      end else begin
        if (level == 8'h00) begin
          dir_up <= 1'b1;
          level  <= level + 8'd1;
        end else begin
          level  <= level - 8'd1;
        end
      end
    end
  end
`else
  logic unused_wrap;
  assign level       = '0;
  assign unused_wrap = pwm_wrap;
`endif

  always_comb begin
    // NOTE: default first so no path through the loop leaves led_next unassigned
    // (which would infer a latch).
    led_next = '0;
    for (int n = 0; n < DWL; n++) begin
      case (led_mode_e'(mode[2*n +: 2]))
        MODE_PASS:    led_next[n] = led_i[n];
        MODE_PWM:     led_next[n] = led_i[n] & (pwm_cnt < bright);
        MODE_BLINK:   led_next[n] = led_i[n] & phase;
`ifdef LED_BREATHE_EN
        MODE_BREATHE: led_next[n] = led_i[n] & (pwm_cnt < level);
`else
        MODE_BREATHE: led_next[n] = led_i[n];
`endif
        default:      led_next[n] = led_i[n];
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_MODE:   rd_mux = 32'(mode);
      ADDR_BRIGHT: rd_mux = {24'd0, bright};
      ADDR_HALF:   rd_mux = {16'd0, half};
      ADDR_STATUS: rd_mux = {15'd0, phase, level, pwm_cnt};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      led_o     <= '0;
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      led_o     <= led_next;
      sys_ack   <= sys_wen | sys_ren;
      sys_rdata <= sys_ren ? rd_mux : 32'd0;
    end
  end

  assign sys_err = 1'b0;

endmodule

// File: tb/tb_red_pitaya_led_drv.sv
// Directed self-checking bench for red_pitaya_led_drv (PRESC=4 for fast ticks).
module tb_red_pitaya_led_drv;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [7:0]  led_i = '0;
  logic [7:0]  led_o;
  logic [31:0] sys_addr = '0;
  logic [31:0] sys_wdata = '0;
  logic [3:0]  sys_sel = 4'hF;
  logic        sys_wen = 1'b0;
  logic        sys_ren = 1'b0;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  red_pitaya_led_drv #(.DWL(8), .PRESC(4), .BLINK_RST(50000)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .led_i     (led_i),
    .led_o     (led_o),
    .sys_addr  (sys_addr),
    .sys_wdata (sys_wdata),
    .sys_sel   (sys_sel),
    .sys_wen   (sys_wen),
    .sys_ren   (sys_ren),
    .sys_rdata (sys_rdata),
    .sys_err   (sys_err),
    .sys_ack   (sys_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk_i); #1;
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    @(posedge clk_i); #1;
    sys_wen = 1'b0;
    check("wr_ack", {31'd0, sys_ack}, 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge clk_i); #1;
    sys_addr = a; sys_ren = 1'b1;
    @(posedge clk_i); #1;
    sys_ren = 1'b0;
    check("rd_ack", {31'd0, sys_ack}, 32'd1);
    d = sys_rdata;
  endtask

  task automatic count_high(input int cycles, output int hi);
    hi = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i); #1;
      hi += int'(led_o[0]);
    end
  endtask

  // Cycles between two consecutive transitions of led_o[0]; -1 on timeout.
  task automatic measure_period(output int p);
    logic prev;
    bit   seen;
    p = -1;
    seen = 1'b0;
    prev = led_o[0];
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk_i); #1;
      if (led_o[0] != prev) seen = 1'b1;
    end
    if (seen) begin
      prev = led_o[0];
      for (int i = 1; i <= 200; i++) begin
        @(posedge clk_i); #1;
        if (led_o[0] != prev) begin
          p = i;
          break;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          hi;
    int          per;

    // Reset state while held in reset
    #1;
    check("rst_led_o", {24'd0, led_o}, 32'd0);
    check("rst_ack", {31'd0, sys_ack}, 32'd0);
    check("rst_rdata", sys_rdata, 32'd0);
    check("rst_err", {31'd0, sys_err}, 32'd0);
    repeat (3) @(posedge clk_i);
    #1 rstn_i = 1'b1;

    // Pass-through with one-cycle latency
    @(posedge clk_i); #1;
    led_i = 8'hA5;
    check("pass_before_edge", {24'd0, led_o}, 32'd0);
    @(posedge clk_i); #1;
    check("pass_a5", {24'd0, led_o}, 32'h0000_00A5);
    bus_read(32'h40, rd);
    check("unmapped_rd", rd, 32'd0);
    check("unmapped_err", {31'd0, sys_err}, 32'd0);
    @(posedge clk_i); #1;
    check("ack_drops", {31'd0, sys_ack}, 32'd0);

    // Asynchronous reset mid-operation
    led_i = 8'hFF;
    bus_write(32'h04, 32'h12);
    bus_write(32'h00, 32'h0003);
    @(posedge clk_i); #3;
    rstn_i = 1'b0;
    #1;
    check("async_rst_led_o", {24'd0, led_o}, 32'd0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rstn_i = 1'b1;
    led_i = 8'h00;
    bus_read(32'h00, rd);  check("rst_mode", rd, 32'd0);
    bus_read(32'h04, rd);  check("rst_bright", rd, 32'h0000_00FF);
    bus_read(32'h08, rd);  check("rst_half", rd, 32'd50000);

    // Back-to-back writes: MODE then STATUS (read-only)
    @(posedge clk_i); #1;
    sys_addr = 32'h00; sys_wdata = 32'h0000_FFFF; sys_wen = 1'b1;
    @(posedge clk_i); #1;
    check("b2b_ack0", {31'd0, sys_ack}, 32'd1);
    sys_addr = 32'h0C; sys_wdata = 32'hFFFF_FFFF;
    @(posedge clk_i); #1;
    sys_wen = 1'b0;
    check("b2b_ack1", {31'd0, sys_ack}, 32'd1);
    bus_read(32'h00, rd);  check("b2b_mode", rd, 32'h0000_FFFF);
    bus_read(32'h0C, rd);  check("status_ro_hi", rd & 32'hFFFE_0000, 32'd0);
    bus_write(32'h40, 32'h1234_5678);
    bus_read(32'h04, rd);  check("unmapped_wr_bright", rd, 32'h0000_00FF);
    bus_read(32'h08, rd);  check("unmapped_wr_half", rd, 32'd50000);

    // PWM dimming: 64/256 duty over one full 1024-clk PWM period
    led_i = 8'h01;
    bus_write(32'h00, 32'h0001);
    bus_write(32'h04, 32'd64);
    repeat (4) @(posedge clk_i);
    count_high(1024, hi);
    check("pwm_64", hi, 32'd256);
    bus_write(32'h04, 32'd0);
    repeat (4) @(posedge clk_i);
    count_high(1024, hi);
    check("pwm_0", hi, 32'd0);
    bus_write(32'h04, 32'd255);
    repeat (4) @(posedge clk_i);
    count_high(1024, hi);
    check("pwm_255", hi, 32'd1020);

    // Blink: HALF=3 -> 12 clk per half-period, HALF=0 and 1 -> 4 clk
    bus_write(32'h00, 32'h0002);
    bus_write(32'h08, 32'd3);
    measure_period(per);
    check("blink_half3", per, 32'd12);
    bus_write(32'h08, 32'd0);
    measure_period(per);
    check("blink_half0", per, 32'd4);
    bus_write(32'h08, 32'd1);
    measure_period(per);
    check("blink_half1", per, 32'd4);

    // HALF write while phase=1 clears phase
    bus_write(32'h08, 32'd3);
    for (int i = 0; i < 100 && led_o[0] !== 1'b1; i++) begin
      @(posedge clk_i); #1;
    end
    check("blink_phase_seen", {31'd0, led_o[0]}, 32'd1);
    bus_write(32'h08, 32'd100);
    @(posedge clk_i); #1;
    check("half_wr_led_off", {31'd0, led_o[0]}, 32'd0);
    bus_read(32'h0C, rd);
    check("half_wr_phase", {31'd0, rd[16]}, 32'd0);

    // Mode 3
    bus_write(32'h00, 32'h0003);
    repeat (2) @(posedge clk_i);
`ifdef LED_BREATHE_EN
    repeat (1100) @(posedge clk_i);
    bus_read(32'h0C, rd);
    check("breathe_level_moving", {31'd0, rd[15:8] != 8'd0}, 32'd1);
`else
    count_high(256, hi);
    check("mode3_pass", hi, 32'd256);
    bus_read(32'h00, rd);
    check("mode3_readback", rd, 32'h0000_0003);
    bus_read(32'h0C, rd);
    check("status_level_zero", rd & 32'h0000_FF00, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
